// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the I-cache
// (read-only) and the D-cache (read/write-back). One block transfer at a time;
// the losing side stays in busywait until it is served.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   -> simultaneous requests go to the side not granted last
//   undefined -> fixed D-side priority (I side may starve)
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   i_read, i_address     I-cache block read request
//   i_readdata            block returned to the I-cache (registered)
//   i_busywait            I-cache stall (combinational)
//   d_read, d_write       D-cache block read / write-back request
//   d_address             D-cache block address
//   d_writedata           D-cache write-back block
//   d_readdata            block returned to the D-cache (registered)
//   d_busywait            D-cache stall (combinational)
//   mem_read, mem_write   memory strobes (registered)
//   mem_address           memory address (registered)
//   mem_writedata         memory write data (registered)
//   mem_readdata          memory read data
//   mem_busywait          memory busy
module mem_arbiter #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t state;
  logic   gnt;     // 0 = I side owns the port, 1 = D side
  logic   first;   // first GRANT cycle: memory busywait not yet valid
  logic   i_req;
  logic   d_req;
  logic   pick_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;    // side granted on the most recent IDLE->GRANT

  // On a tie, D wins only if I was granted last.
  assign pick_d = d_req & ~(i_req & last_d);
`else
  assign pick_d = d_req;
`endif

  // Owner is released only in the RELEASE cycle; otherwise a request stalls.
  assign i_busywait = i_req & ~((state == S_RELEASE) & ~gnt);
  assign d_busywait = d_req & ~((state == S_RELEASE) &  gnt);

  // Transfer sequencer with registered memory-side and read-data outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      gnt           <= 1'b0;
      first         <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      i_readdata    <= '0;
      d_readdata    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d        <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req | d_req) begin
            gnt           <= pick_d;
            first         <= 1'b1;
            mem_address   <= pick_d ? d_address : i_address;
            mem_writedata <= pick_d ? d_writedata : '0;
            // A simultaneous D read+write is treated as a write.
            mem_write     <= pick_d & d_write;
            mem_read      <= ~(pick_d & d_write);
`ifdef ARB_ROUND_ROBIN_EN
            last_d        <= pick_d;
`endif
            state         <= S_GRANT;
          end
        end
        S_GRANT: begin
          first <= 1'b0;
          // Transfer runs to completion even if the owner drops its request.
          if (!first && !mem_busywait) begin
            if (mem_read) begin
              if (gnt) d_readdata <= mem_readdata;
              else     i_readdata <= mem_readdata;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. Expected memory
// transactions are queued when requests are driven and popped when the
// arbiter raises a memory strobe; read data is checked on release.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_readdata;
  logic              i_busywait;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_writedata;
  logic [DATA_W-1:0] d_readdata;
  logic              d_busywait;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_busywait;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_read        (i_read),
    .i_address     (i_address),
    .i_readdata    (i_readdata),
    .i_busywait    (i_busywait),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_address     (d_address),
    .d_writedata   (d_writedata),
    .d_readdata    (d_readdata),
    .d_busywait    (d_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] pat(input logic [5:0] a);
    if (a == 6'h0A) return 32'hDEADBEEF;
    return 32'hA5C30000 | 32'(a);
  endfunction

  // Memory model: busywait rises the cycle after a new strobe and stays high
  // long enough that the arbiter completes lat+1 cycles after the strobe.
  logic [31:0] mem [64];
  int          lat = 5;
  int          cnt;
  logic        prev_strobe;

  always @(posedge clk) begin
    if (reset) begin
      mem_busywait <= 1'b0;
      prev_strobe  <= 1'b0;
      cnt          <= 0;
      for (int a = 0; a < 64; a++) mem[a] <= pat(6'(a));
    end else begin
      prev_strobe <= mem_read | mem_write;
      if ((mem_read | mem_write) && !prev_strobe) begin
        mem_busywait <= 1'b1;
        cnt          <= lat - 2;
        if (mem_write) mem[mem_address] <= mem_writedata;
      end else if (mem_busywait) begin
        if (cnt == 0) mem_busywait <= 1'b0;
        else          cnt <= cnt - 1;
      end
    end
  end

  assign mem_readdata = mem[mem_address];

  typedef struct {
    bit          side;   // 0 = I, 1 = D
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } txn_t;

  txn_t        sb[$];
  txn_t        cur;
  bit          active = 1'b0;
  int          hi_cnt;
  logic [31:0] exp_i = '0;
  logic [31:0] exp_d = '0;

  // Strobe monitor, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      active = 1'b0;
      exp_i  = '0;
      exp_d  = '0;
    end else if ((mem_read | mem_write) && !active) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 64'(mem_address), 64'hFFFF);
      end else begin
        cur    = sb.pop_front();
        active = 1'b1;
        hi_cnt = 1;
        check("mem_write", 64'(mem_write), 64'(cur.wr));
        check("mem_read", 64'(mem_read), 64'(!cur.wr));
        check("mem_address", 64'(mem_address), 64'(cur.addr));
        if (cur.wr) check("mem_writedata", 64'(mem_writedata), 64'(cur.wd));
      end
    end else if ((mem_read | mem_write) && active) begin
      hi_cnt++;
    end else if (active) begin
      active = 1'b0;
      check("strobe_len", 64'(hi_cnt), 64'(lat + 1));
      if (cur.side) begin
        if (!cur.wr) exp_d = cur.rd;
        check("d_readdata", 64'(d_readdata), 64'(exp_d));
        check("i_readdata_hold", 64'(i_readdata), 64'(exp_i));
      end else begin
        exp_i = cur.rd;
        check("i_readdata", 64'(i_readdata), 64'(exp_i));
        check("d_readdata_hold", 64'(d_readdata), 64'(exp_d));
      end
    end
  end

  // Waits for the given side's busywait to go low; n = stalled negedges.
  task automatic wait_rel(input bit side, output int n);
    logic bw;
    n = 0;
    forever begin
      @(negedge clk);
      bw = side ? d_busywait : i_busywait;
      if (!bw) break;
      n++;
      if (n > 200) break;
    end
  endtask

  task automatic push(input bit side, input bit wr, input logic [5:0] addr,
                      input logic [31:0] wd);
    txn_t t;
    t.side = side;
    t.wr   = wr;
    t.addr = addr;
    t.wd   = wd;
    t.rd   = wr ? 32'h0 : pat(addr);
    sb.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n1, n2, n3;
    reset       = 1'b1;
    i_read      = 1'b1;
    i_address   = '0;
    d_read      = 1'b0;
    d_write     = 1'b1;
    d_address   = '0;
    d_writedata = '0;

    // Reset with both sides requesting.
    repeat (2) @(negedge clk);
    check("rst_mem_read", 64'(mem_read), 64'd0);
    check("rst_mem_write", 64'(mem_write), 64'd0);
    check("rst_mem_address", 64'(mem_address), 64'd0);
    check("rst_mem_writedata", 64'(mem_writedata), 64'd0);
    check("rst_i_readdata", 64'(i_readdata), 64'd0);
    check("rst_d_readdata", 64'(d_readdata), 64'd0);
    check("rst_i_busywait", 64'(i_busywait), 64'd1);
    check("rst_d_busywait", 64'(d_busywait), 64'd1);
    reset   = 1'b0;
    i_read  = 1'b0;
    d_write = 1'b0;
    repeat (2) @(negedge clk);

    // Single I read, latency 5.
    lat = 5;
    push(1'b0, 1'b0, 6'h0A, 32'h0);
    i_address = 6'h0A;
    i_read    = 1'b1;
    wait_rel(1'b0, n1);
    i_read = 1'b0;
    check("i_single_stall", 64'(n1), 64'd6);
    repeat (2) @(negedge clk);

    // Simultaneous I read and D write: D first, I held through both.
    push(1'b1, 1'b1, 6'h03, 32'h12345678);
    push(1'b0, 1'b0, 6'h11, 32'h0);
    i_address   = 6'h11;
    d_address   = 6'h03;
    d_writedata = 32'h12345678;
    i_read      = 1'b1;
    d_write     = 1'b1;
    fork
      begin wait_rel(1'b1, n1); d_write = 1'b0; end
      begin wait_rel(1'b0, n2); i_read  = 1'b0; end
    join
    check("conflict_d_stall", 64'(n1), 64'd6);
    check("conflict_i_stall", 64'(n2), 64'd14);
    repeat (2) @(negedge clk);

    // D keeps requesting back to back while I waits; latency 3.
    lat = 3;
`ifdef ARB_ROUND_ROBIN_EN
    push(1'b1, 1'b0, 6'h20, 32'h0);
    push(1'b0, 1'b0, 6'h12, 32'h0);
    push(1'b1, 1'b0, 6'h21, 32'h0);
`else
    push(1'b1, 1'b0, 6'h20, 32'h0);
    push(1'b1, 1'b0, 6'h21, 32'h0);
    push(1'b0, 1'b0, 6'h12, 32'h0);
`endif
    i_address = 6'h12;
    d_address = 6'h20;
    i_read    = 1'b1;
    d_read    = 1'b1;
    fork
      begin
        wait_rel(1'b1, n1);
        d_address = 6'h21;
        wait_rel(1'b1, n2);
        d_read = 1'b0;
      end
      begin wait_rel(1'b0, n3); i_read = 1'b0; end
    join
    check("burst_d1_stall", 64'(n1), 64'd4);
`ifdef ARB_ROUND_ROBIN_EN
    check("burst_d2_stall", 64'(n2), 64'd11);
    check("burst_i_stall", 64'(n3), 64'd10);
`else
    check("burst_d2_stall", 64'(n2), 64'd5);
    check("burst_i_stall", 64'(n3), 64'd16);
`endif
    repeat (2) @(negedge clk);

    // D read dropped two cycles into the grant still completes.
    lat = 5;
    push(1'b1, 1'b0, 6'h05, 32'h0);
    d_address = 6'h05;
    d_read    = 1'b1;
    repeat (2) @(negedge clk);
    d_read = 1'b0;
    repeat (12) @(negedge clk);
    check("drop_d_readdata", 64'(d_readdata), 64'(pat(6'h05)));
    check("drop_no_rearb", 64'(mem_read | mem_write), 64'd0);
    check("drop_sb_empty", 64'(sb.size()), 64'd0);

    // Reset in the third GRANT cycle aborts the transfer.
    push(1'b0, 1'b0, 6'h07, 32'h0);
    i_address = 6'h07;
    i_read    = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_mem_read", 64'(mem_read), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_mem_read", 64'(mem_read), 64'd0);
    check("midrst_mem_address", 64'(mem_address), 64'd0);
    check("midrst_i_readdata", 64'(i_readdata), 64'd0);
    check("midrst_d_readdata", 64'(d_readdata), 64'd0);
    check("midrst_i_busywait", 64'(i_busywait), 64'd1);
    reset  = 1'b0;
    i_read = 1'b0;
    repeat (4) @(negedge clk);
    check("final_idle", 64'(mem_read | mem_write), 64'd0);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
